// File: rtl/execute_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU
// functions, branch/cmov conditions and the condition-code register layout.
package execute_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  typedef enum logic [3:0] {
    C_YES = 4'd0,
    C_LE  = 4'd1,
    C_L   = 4'd2,
    C_E   = 4'd3,
    C_NE  = 4'd4,
    C_GE  = 4'd5,
    C_G   = 4'd6
  } cond_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  localparam logic [3:0] ALU_IFUN_MAX  = 4'd3;
  localparam logic [3:0] COND_IFUN_MAX = 4'd6;

  // Condition encodings above C_G never reach here; the caller flags them.
  function automatic logic cond_eval(input cond_e c, input cc_t cc);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (c)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | cc.zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = cc.zf;
      C_NE:    cond_eval = ~cc.zf;
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~cc.zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_if.sv
// Decode/fetch-to-execute bundle: operands and codes in, ALU result,
// condition and CC contents out.
interface execute_if #(
  parameter int unsigned WIDTH = 64
);
  logic             cc_en;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic [WIDTH-1:0] valC;
  logic [WIDTH-1:0] valE;
  logic             cnd;
  logic             zf;
  logic             sf;
  logic             of;
  logic             ex_err;

  modport master (
    output cc_en, icode, ifun, valA, valB, valC,
    input  valE, cnd, zf, sf, of, ex_err
  );

  modport slave (
    input  cc_en, icode, ifun, valA, valB, valC,
    output valE, cnd, zf, sf, of, ex_err
  );
endinterface

// File: rtl/execute_alu.sv
// Combinational WIDTH-bit ALU computing b <op> a, with zero/sign/overflow
// flags for the caller's condition-code register.
module alu
  import execute_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_fun_e         fun,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = b + a;
        of     = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (b[WIDTH-1] != a[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = '0;
    endcase
    zf = (result == '0);
    sf = result[WIDTH-1];
  end

endmodule

// File: rtl/execute.sv
// Y86-64 SEQ execute stage: selects ALU operands per icode, produces valE and
// cnd combinationally, and owns the ZF/SF/OF condition-code register.
module execute
  import execute_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input logic     clk,
  input logic     rst,
  execute_if.slave ex
);

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  alu_fun_e         alu_fun;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zf;
  logic             alu_sf;
  logic             alu_of;

  logic [WIDTH-1:0] val_e;
  logic             cnd;
  logic             ex_err;
  logic             op_ok;
  logic             cond_sel;
  cc_t              cc_d;
  cc_t              cc_q;

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fun    (alu_fun),
    .result (alu_res),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  always_comb begin
    alu_a    = ex.valA;
    alu_b    = ex.valB;
    alu_fun  = ALU_ADD;
    val_e    = '0;
    ex_err   = 1'b0;
    cnd      = 1'b1;
    op_ok    = (ex.ifun <= ALU_IFUN_MAX);
    cond_sel = 1'b0;

    // Stack and address arithmetic reuse the ALU as b+x / b-x.
    case (ex.icode)
      I_HALT, I_NOP: val_e = '0;
      I_JXX: begin
        val_e    = '0;
        cond_sel = 1'b1;
      end
      I_RRMOVQ: begin
        val_e    = ex.valA;
        cond_sel = 1'b1;
      end
      I_IRMOVQ: val_e = ex.valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = ex.valC;
        val_e = alu_res;
      end
      I_OPQ: begin
        if (op_ok) begin
          alu_fun = alu_fun_e'(ex.ifun[1:0]);
          val_e   = alu_res;
        end else begin
          ex_err = 1'b1;
        end
      end
      I_CALL, I_PUSHQ: begin
        alu_a   = WIDTH'(8);
        alu_fun = ALU_SUB;
        val_e   = alu_res;
      end
      I_RET, I_POPQ: begin
        alu_a = WIDTH'(8);
        val_e = alu_res;
      end
      default: ex_err = 1'b1;
    endcase

    if (cond_sel) begin
      if (ex.ifun > COND_IFUN_MAX) begin
        cnd    = 1'b0;
        ex_err = 1'b1;
      end else begin
        cnd = cond_eval(cond_e'(ex.ifun), cc_q);
      end
    end

    cc_d = cc_q;
    if (ex.cc_en && (ex.icode == I_OPQ) && op_ok) begin
      cc_d = '{zf: alu_zf, sf: alu_sf, of: alu_of};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign ex.valE   = val_e;
  assign ex.cnd    = cnd;
  assign ex.ex_err = ex_err;
  assign ex.zf     = cc_q.zf;
  assign ex.sf     = cc_q.sf;
  assign ex.of     = cc_q.of;

endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the execute stage with hand-computed expectations.
module tb_execute;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  execute_if #(.WIDTH(64)) bus ();

  execute #(
    .WIDTH(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bus.icode = ic;
    bus.ifun  = fn;
    bus.valA  = a;
    bus.valB  = b;
    bus.valC  = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_cc(input string tag, input logic z, input logic s, input logic o);
    check({tag, "_zf"}, 64'(bus.zf), 64'(z));
    check({tag, "_sf"}, 64'(bus.sf), 64'(s));
    check({tag, "_of"}, 64'(bus.of), 64'(o));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    bus.cc_en = 1'b0;
    bus.icode = 4'h1;
    bus.ifun  = 4'h0;
    bus.valA  = '0;
    bus.valB  = '0;
    bus.valC  = '0;

    // Reset asserted between clock edges
    #2 rst = 1'b1;
    #1;
    check_cc("reset", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    drive(4'h7, 4'h3, '0, '0, '0);
    check("reset_je_cnd", 64'(bus.cnd), 64'd1);
    check("reset_je_err", 64'(bus.ex_err), 64'd0);

    // OPq sub: 5 - 7 = -2
    tick();
    bus.cc_en = 1'b1;
    drive(4'h6, 4'h1, 64'd7, 64'd5, '0);
    check("sub_valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_err", 64'(bus.ex_err), 64'd0);
    check("sub_cnd", 64'(bus.cnd), 64'd1);
    tick();
    check_cc("sub", 1'b0, 1'b1, 1'b0);
    drive(4'h7, 4'h2, '0, '0, '0);
    check("sub_jl_cnd", 64'(bus.cnd), 64'd1);
    drive(4'h7, 4'h3, '0, '0, '0);
    check("sub_je_cnd", 64'(bus.cnd), 64'd0);
    drive(4'h7, 4'h6, '0, '0, '0);
    check("sub_jg_cnd", 64'(bus.cnd), 64'd0);

    // Stack, memory, constant and nop paths; CC must not move
    drive(4'hA, 4'h0, '0, 64'h100, '0);
    check("pushq_valE", bus.valE, 64'hF8);
    tick();
    drive(4'hB, 4'h0, '0, 64'h100, '0);
    check("popq_valE", bus.valE, 64'h108);
    tick();
    drive(4'h5, 4'h0, '0, 64'h10, 64'h20);
    check("mrmovq_valE", bus.valE, 64'h30);
    tick();
    check_cc("memops", 1'b0, 1'b1, 1'b0);
    drive(4'h3, 4'h0, 64'h55, 64'h66, 64'h1234);
    check("irmovq_valE", bus.valE, 64'h1234);
    drive(4'h1, 4'h0, 64'h55, 64'h66, 64'h77);
    check("nop_valE", bus.valE, 64'h0);

    // Signed overflow on add
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, '0);
    check("ovf_valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check_cc("ovf", 1'b0, 1'b1, 1'b1);
    drive(4'h7, 4'h1, '0, '0, '0);
    check("ovf_jle_cnd", 64'(bus.cnd), 64'd0);
    drive(4'h7, 4'h5, '0, '0, '0);
    check("ovf_jge_cnd", 64'(bus.cnd), 64'd1);
    drive(4'h7, 4'h2, '0, '0, '0);
    check("ovf_jl_cnd", 64'(bus.cnd), 64'd0);

    // CC write enable gating
    bus.cc_en = 1'b0;
    drive(4'h6, 4'h3, 64'd9, 64'd9, '0);
    check("xor_valE", bus.valE, 64'h0);
    tick();
    check_cc("gated", 1'b0, 1'b1, 1'b1);
    bus.cc_en = 1'b1;
    tick();
    check_cc("ungated", 1'b1, 1'b0, 1'b0);
    drive(4'h7, 4'h4, '0, '0, '0);
    check("ungated_jne_cnd", 64'(bus.cnd), 64'd0);

    // Restore a non-reset CC, then illegal codes
    drive(4'h6, 4'h1, 64'd7, 64'd5, '0);
    tick();
    drive(4'h6, 4'h4, 64'd1, 64'd2, '0);
    check("badop_err", 64'(bus.ex_err), 64'd1);
    check("badop_valE", bus.valE, 64'h0);
    tick();
    check_cc("badop", 1'b0, 1'b1, 1'b0);
    drive(4'h7, 4'h7, '0, '0, '0);
    check("badj_err", 64'(bus.ex_err), 64'd1);
    check("badj_cnd", 64'(bus.cnd), 64'd0);
    drive(4'h2, 4'h7, 64'hAB, '0, '0);
    check("badcmov_err", 64'(bus.ex_err), 64'd1);
    check("badcmov_cnd", 64'(bus.cnd), 64'd0);
    drive(4'hC, 4'h0, 64'h1, 64'h2, 64'h3);
    check("badicode_err", 64'(bus.ex_err), 64'd1);
    check("badicode_valE", bus.valE, 64'h0);
    tick();
    drive(4'h7, 4'h6, '0, '0, '0);
    check("jg_err", 64'(bus.ex_err), 64'd0);

    // cmovXX: valE is valA regardless of cnd
    drive(4'h2, 4'h4, 64'hDEAD, '0, '0);
    check("cmovne_cnd", 64'(bus.cnd), 64'd1);
    check("cmovne_valE", bus.valE, 64'hDEAD);
    drive(4'h2, 4'h3, 64'hBEEF, '0, '0);
    check("cmove_cnd", 64'(bus.cnd), 64'd0);
    check("cmove_valE", bus.valE, 64'hBEEF);

    // Reset mid-program: CC and cnd follow immediately
    drive(4'h7, 4'h3, '0, '0, '0);
    check("pre_rst_je_cnd", 64'(bus.cnd), 64'd0);
    rst = 1'b1;
    #1;
    check_cc("midrst", 1'b1, 1'b0, 1'b0);
    check("midrst_je_cnd", 64'(bus.cnd), 64'd1);
    rst = 1'b0;
    drive(4'h1, 4'h0, '0, '0, '0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
